// File: rtl/router_out_reader.sv
// Drain engine for one router output port: reads a packet out of the port FIFO, forwards the
// payload under sink backpressure, and reports parity/address status or a soft-reset abort.
module router_out_reader #(
    parameter logic [1:0]  DEST_ADDR   = 2'b00,
    parameter int unsigned START_DELAY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       soft_reset,
    input  logic       sink_ready,
    output logic       read_enb,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       addr_err,
    output logic       pkt_abort,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StHdrRd,
        StHdrCap,
        StBody,
        StDone
    } state_e;

    localparam logic [4:0] DelayLast = (START_DELAY == 0) ? 5'd0 : 5'(START_DELAY - 1);

    state_e     state_q, state_d;
    logic [4:0] delay_q;
    logic [6:0] issue_q;
    logic [6:0] cap_q;
    logic       rd_q;
    logic [7:0] hdr_q;
    logic [7:0] xor_q;
    logic       cap_payload;
    logic       cap_parity;

    // rd_q marks the cycle in which data_out holds the byte read one cycle earlier
    assign cap_payload = (state_q == StBody) && rd_q && (cap_q > 7'd1);
    assign cap_parity  = (state_q == StBody) && rd_q && (cap_q == 7'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vld_out) begin
                    state_d = (START_DELAY == 0) ? StHdrRd : StDelay;
                end
            end
            StDelay: begin
                if (delay_q == DelayLast) begin
                    state_d = StHdrRd;
                end
            end
            StHdrRd:  state_d = StHdrCap;
            StHdrCap: state_d = StBody;
            StBody: begin
                if (cap_parity) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (soft_reset) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        read_enb = 1'b0;
        unique case (state_q)
            StHdrRd: read_enb = 1'b1;
            StBody:  read_enb = (issue_q != 7'd0) && vld_out && sink_ready;
            default: read_enb = 1'b0;
        endcase
        if (soft_reset) begin
            read_enb = 1'b0;
        end
        busy     = (state_q != StIdle);
        pkt_done = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            delay_q    <= 5'd0;
            issue_q    <= 7'd0;
            cap_q      <= 7'd0;
            rd_q       <= 1'b0;
            hdr_q      <= 8'd0;
            xor_q      <= 8'd0;
            out_valid  <= 1'b0;
            out_data   <= 8'd0;
            out_last   <= 1'b0;
            pkt_len    <= 6'd0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_abort  <= 1'b0;
        end else begin
            rd_q      <= read_enb;
            pkt_abort <= soft_reset && (state_q != StIdle);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (soft_reset) begin
                delay_q <= 5'd0;
                issue_q <= 7'd0;
                cap_q   <= 7'd0;
            end else begin
                delay_q <= (state_q == StDelay) ? delay_q + 5'd1 : 5'd0;
                if (state_q == StHdrCap) begin
                    hdr_q   <= data_out;
                    xor_q   <= data_out;
                    issue_q <= {1'b0, data_out[7:2]} + 7'd1;
                    cap_q   <= {1'b0, data_out[7:2]} + 7'd1;
                end
                if ((state_q == StBody) && read_enb) begin
                    issue_q <= issue_q - 7'd1;
                end
                if ((state_q == StBody) && rd_q) begin
                    cap_q <= cap_q - 7'd1;
                end
                if (cap_payload) begin
                    out_valid <= 1'b1;
                    out_data  <= data_out;
                    out_last  <= (cap_q == 7'd2);
                    xor_q     <= xor_q ^ data_out;
                end
                if (cap_parity) begin
                    pkt_len    <= hdr_q[7:2];
                    parity_err <= (xor_q != data_out);
                    addr_err   <= (hdr_q[1:0] != DEST_ADDR);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_out_reader.sv
// Bench for router_out_reader: a queue-based FIFO feeds packets, a packet-level model predicts
// forwarded bytes and completion status, and directed tests pin latencies literally.
module tb_router_out_reader;

    localparam logic [1:0]  DEST = 2'b00;
    localparam int unsigned SD   = 4;

    logic       clk = 1'b0;
    logic       reset, vld_out, soft_reset, sink_ready;
    logic [7:0] data_out;
    logic       read_enb, out_valid, out_last, pkt_done, parity_err, addr_err, pkt_abort, busy;
    logic [7:0] out_data;
    logic [5:0] pkt_len;

    always #5 clk = ~clk;

    router_out_reader #(.DEST_ADDR(DEST), .START_DELAY(SD)) dut (
        .clk(clk), .reset(reset), .vld_out(vld_out), .data_out(data_out),
        .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .pkt_done(pkt_done),
        .pkt_len(pkt_len), .parity_err(parity_err), .addr_err(addr_err),
        .pkt_abort(pkt_abort), .busy(busy)
    );

    typedef struct {int id; logic [7:0] data; logic last;} exp_byte_t;
    typedef struct {int id; logic [5:0] len; logic perr; logic aerr;} exp_done_t;

    exp_byte_t  exp_bytes[$];
    exp_done_t  exp_done[$];
    logic [7:0] fifo[$];
    logic [7:0] cur_pkt[$];

    int checks = 0, errors = 0;
    int cyc = 0, pkt_id = 0, done_cnt = 0, abort_cnt = 0, bytes_seen = 0;
    int first_out_cyc = 0, last_done_cyc = 0, push_cyc = 0;
    logic [5:0] last_len = 6'd0;
    logic last_perr = 1'b0, last_aerr = 1'b0, abort_armed = 1'b0, re_s = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level prediction from the packet format alone
    task automatic add_model();
        logic [7:0] hdr, x;
        int len;
        exp_byte_t b;
        exp_done_t d;
        hdr = cur_pkt[0];
        len = int'(hdr[7:2]);
        x   = hdr;
        for (int i = 0; i < len; i++) begin
            x      ^= cur_pkt[i+1];
            b.id   = pkt_id;
            b.data = cur_pkt[i+1];
            b.last = (i == len - 1);
            exp_bytes.push_back(b);
        end
        d.id   = pkt_id;
        d.len  = hdr[7:2];
        d.perr = (cur_pkt[len+1] != x);
        d.aerr = (hdr[1:0] != DEST);
        exp_done.push_back(d);
        pkt_id++;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) fifo.push_back(cur_pkt[i]);
        vld_out = (fifo.size() != 0);
    endtask

    task automatic load_pkt();
        add_model();
        push_range(0, cur_pkt.size() - 1);
        push_cyc = cyc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (soft_reset) fifo.delete();
        else if (re_s && fifo.size() > 0) data_out = fifo.pop_front();
        vld_out = (fifo.size() != 0);
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < 300) begin
            tick();
            k++;
        end
        chk("done_timeout", 32'(done_cnt), 32'(n));
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (bytes_seen < n && k < 300) begin
            tick();
            k++;
        end
        chk("byte_timeout", 32'(bytes_seen), 32'(n));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            re_s = read_enb;
            if (!reset) begin
                if (fifo.size() == 0) chk("read_empty_fifo", 32'(read_enb), 0);
                if (soft_reset) chk("read_during_soft_reset", 32'(read_enb), 0);
                if (out_valid) begin
                    if (exp_bytes.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 0);
                    end else begin
                        exp_byte_t e;
                        e = exp_bytes.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.data));
                        chk("out_last", 32'(out_last), 32'(e.last));
                    end
                    if (bytes_seen == 0) first_out_cyc = cyc;
                    bytes_seen++;
                end
                if (pkt_done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_pkt_done", 32'(pkt_done), 0);
                    end else begin
                        exp_done_t d;
                        int pend;
                        d    = exp_done.pop_front();
                        pend = 0;
                        foreach (exp_bytes[i]) if (exp_bytes[i].id == d.id) pend++;
                        chk("lost_bytes", 32'(pend), 0);
                        chk("pkt_len", 32'(pkt_len), 32'(d.len));
                        chk("parity_err", 32'(parity_err), 32'(d.perr));
                        chk("addr_err", 32'(addr_err), 32'(d.aerr));
                    end
                    last_len      = pkt_len;
                    last_perr     = parity_err;
                    last_aerr     = addr_err;
                    last_done_cyc = cyc;
                    done_cnt++;
                    bytes_seen = 0;
                end
                if (pkt_abort) begin
                    if (!abort_armed) begin
                        chk("unexpected_pkt_abort", 32'(pkt_abort), 0);
                    end else if (exp_done.size() > 0) begin
                        exp_done_t d;
                        d = exp_done.pop_front();
                        while (exp_bytes.size() > 0 && exp_bytes[0].id == d.id)
                            void'(exp_bytes.pop_front());
                    end
                    abort_cnt++;
                    abort_armed = 1'b0;
                    bytes_seen  = 0;
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        vld_out    = 1'b0;
        data_out   = 8'h00;
        soft_reset = 1'b0;
        sink_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 32'({read_enb, out_valid, out_data, out_last, pkt_done, pkt_len,
                                  parity_err, addr_err, pkt_abort, busy}), 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Basic packet, latency pinned by hand
        cur_pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        load_pkt();
        wait_done(1);
        chk("t1_first_byte_latency", 32'(first_out_cyc - push_cyc), 9);
        chk("t1_done_latency", 32'(last_done_cyc - push_cyc), 12);
        chk("t1_len", 32'(last_len), 3);
        chk("t1_perr", 32'(last_perr), 0);
        repeat (2) tick();

        // Bad parity followed back-to-back by a zero-length packet
        cur_pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0D};
        load_pkt();
        cur_pkt = '{8'h00, 8'h00};
        load_pkt();
        wait_done(2);
        chk("t2_perr", 32'(last_perr), 1);
        wait_done(3);
        chk("t3_len", 32'(last_len), 0);
        chk("t3_errs", 32'({last_perr, last_aerr}), 0);
        repeat (2) tick();

        // Address mismatch still drains
        cur_pkt = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hD0};
        load_pkt();
        wait_done(4);
        chk("t4_aerr", 32'(last_aerr), 1);
        chk("t4_perr", 32'(last_perr), 0);
        repeat (2) tick();

        // Sink stall of 5 cycles after the second payload byte
        cur_pkt = '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14};
        load_pkt();
        wait_bytes(2);
        sink_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_read_enb", 32'(read_enb), 0);
            tick();
        end
        sink_ready = 1'b1;
        wait_done(5);
        chk("t5_done_latency", 32'(last_done_cyc - push_cyc), 18);
        repeat (2) tick();

        // Slow writer: FIFO runs empty mid-packet
        cur_pkt = '{8'h08, 8'h5A, 8'hA5, 8'hF7};
        add_model();
        push_range(0, 1);
        repeat (12) tick();
        chk("slow_busy", 32'(busy), 1);
        push_range(2, 3);
        wait_done(6);
        chk("t6_len", 32'(last_len), 2);
        repeat (2) tick();

        // Soft reset in BODY
        cur_pkt = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h15};
        load_pkt();
        wait_bytes(1);
        abort_armed = 1'b1;
        soft_reset  = 1'b1;
        #1;
        chk("soft_reset_read_enb", 32'(read_enb), 0);
        tick();
        soft_reset = 1'b0;
        chk("abort_pulse", 32'(pkt_abort), 1);
        chk("abort_busy", 32'(busy), 0);
        tick();
        chk("abort_one_cycle", 32'(pkt_abort), 0);
        repeat (10) tick();
        chk("abort_no_done", 32'(done_cnt), 6);
        chk("abort_count", 32'(abort_cnt), 1);

        // Next packet after the abort parses normally
        cur_pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        load_pkt();
        wait_done(7);
        chk("t8_done_latency", 32'(last_done_cyc - push_cyc), 12);
        repeat (3) tick();

        chk("exp_bytes_left", 32'(exp_bytes.size()), 0);
        chk("exp_done_left", 32'(exp_done.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
